// File: rtl/dl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | dl_pkg: shared types and helpers for the ROM download router.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dl_pkg;

   localparam int MAX_AW    = 32;
   localparam int MAX_LW    = 2;
   localparam int MAX_LANES = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } port_state_e;

   // Fields are sized for the widest legal port; narrower ports zero-fill.
   typedef struct packed {
      logic [MAX_AW-1:0] addr;
      logic [MAX_LW-1:0] lane;
      logic [7:0]        data;
   } dl_entry_t;

   function automatic int lw_of(input int lanes);
      return (lanes >= 4) ? 2 : ((lanes == 2) ? 1 : 0);
   endfunction

   function automatic logic [MAX_LANES-1:0] lane_onehot(input logic [MAX_LW-1:0] off,
                                                        input int lanes);
      logic [MAX_LANES-1:0] oh;
      oh = '0;
      if (lanes <= 1) oh[0] = 1'b1;
      else            oh[off] = 1'b1;
      return oh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dl_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | dl_fifo: synchronous FIFO with occupancy count; a pop frees a slot   |
// | for a same-cycle push even when full.            Rev 1.0             |
// +----------------------------------------------------------------------+
module dl_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             full, empty, do_rd, do_wr;

   assign full  = (cnt_q == (PW+1)'(DEPTH));
   assign empty = (cnt_q == '0);

   always_comb begin
      do_rd = i_rd_en && !empty;
      do_wr = i_wr_en && (!full || do_rd);
      wp_d  = do_wr ? wp_q + 1'b1 : wp_q;
      rp_d  = do_rd ? rp_q + 1'b1 : rp_q;
      cnt_d = cnt_q;
      if (do_wr && !do_rd)      cnt_d = cnt_q + 1'b1;
      else if (!do_wr && do_rd) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wp_q] <= i_wr_data;
   end

   assign o_rd_data = mem_q[rp_q];
   assign o_count   = cnt_q;
   assign o_full    = full;
   assign o_empty   = empty;

endmodule
`default_nettype wire

// File: rtl/rom_dl_router.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_dl_router: routes the ioctl byte stream into per-port FIFOs and  |
// | toggle-handshake writers; sequences rom_loaded and core reset. 1.0   |
// +----------------------------------------------------------------------+
module rom_dl_router
   import dl_pkg::*;
#(
   parameter int          NPORTS     = 2,
   parameter int          AW         = 25,
   parameter int          DW         = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  ROM_INDEX  = 8'h00,
   parameter logic [15:0] RESET_HOLD = 16'hFFFF
) (
   input  logic                                    clk_sys,
   input  logic                                    reset,
   input  logic                                    ioctl_download,
   input  logic [7:0]                              ioctl_index,
   input  logic                                    ioctl_wr,
   input  logic [AW-1:0]                           ioctl_addr,
   input  logic [7:0]                              ioctl_dout,
   output logic                                    ioctl_wait,
   input  logic [NPORTS*AW-1:0]                    region_base,
   input  logic [NPORTS*AW-1:0]                    region_end,
   output logic [NPORTS-1:0]                       port_req,
   input  logic [NPORTS-1:0]                       port_ack,
   output logic [NPORTS*(AW-$clog2(DW/8))-1:0]     port_a,
   output logic [NPORTS*(DW/8)-1:0]                port_ds,
   output logic [NPORTS*DW-1:0]                    port_d,
   output logic [NPORTS-1:0]                       port_we,
   input  logic                                    reset_req,
   output logic                                    rom_loaded,
   output logic                                    core_reset,
   output logic                                    overflow
);

   localparam int LANES = DW / 8;
   localparam int LW    = lw_of(LANES);
   localparam int WA    = AW - LW;
   localparam int EW    = $bits(dl_entry_t);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   logic          wr_q, wr_d, dl_q, dl_d, stb_q, stb_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    dout_q, dout_d;
   logic          drain_q, drain_d, rom_loaded_q, rom_loaded_d;
   logic          overflow_q, overflow_d, core_reset_q, core_reset_d;
   logic [15:0]   cnt_q, cnt_d;

   logic [NPORTS-1:0] drop_v, active_v, near_v;

   for (genvar i = 0; i < NPORTS; i++) begin : g_port
      logic [AW-1:0]        base, lim, off;
      logic                 match, push, pop, full, empty;
      logic [CW-1:0]        count;
      dl_entry_t            wr_ent, head;
      logic [MAX_LANES-1:0] oh;
      port_state_e          state_q, state_d;
      logic                 req_q, req_d, we_q, we_d;
      logic [WA-1:0]        a_q, a_d;
      logic [LANES-1:0]     ds_q, ds_d;
      logic [DW-1:0]        d_q, d_d;
      logic                 unused_bits;

      assign base = region_base[i*AW +: AW];
      assign lim  = region_end[i*AW +: AW];

      // An inverted or zero-length region simply never matches.
      always_comb begin
         match       = (addr_q >= base) && (addr_q < lim);
         off         = addr_q - base;
         push        = stb_q && match;
         wr_ent.addr = MAX_AW'(off >> LW);
         wr_ent.lane = MAX_LW'(off) & MAX_LW'(LANES - 1);
         wr_ent.data = dout_q;
      end

      dl_fifo #(
         .WIDTH (EW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk_sys),
         .rst       (reset),
         .i_wr_en   (push),
         .i_wr_data (wr_ent),
         .i_rd_en   (pop),
         .o_rd_data (head),
         .o_count   (count),
         .o_full    (full),
         .o_empty   (empty)
      );

      always_comb begin
         state_d = state_q;
         req_d   = req_q;
         we_d    = we_q;
         a_d     = a_q;
         ds_d    = ds_q;
         d_d     = d_q;
         pop     = 1'b0;
         oh      = lane_onehot(head.lane, LANES);
         case (state_q)
            ST_IDLE: begin
               if (!empty) begin
                  pop     = 1'b1;
                  a_d     = head.addr[WA-1:0];
                  ds_d    = oh[LANES-1:0];
                  d_d     = {LANES{head.data}};
                  req_d   = ~req_q;
                  we_d    = 1'b1;
                  state_d = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (port_ack[i] == req_q) begin
                  we_d    = 1'b0;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Reset adopts the ack level so an abandoned write never looks pending.
      always_ff @(posedge clk_sys) begin
         if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= port_ack[i];
            we_q    <= 1'b0;
            a_q     <= '0;
            ds_q    <= '0;
            d_q     <= '0;
         end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            a_q     <= a_d;
            ds_q    <= ds_d;
            d_q     <= d_d;
         end
      end

      assign drop_v[i]   = push && full && !pop;
      assign active_v[i] = !empty || (state_q != ST_IDLE);
      assign near_v[i]   = (count >= CW'(FIFO_DEPTH - 1));

      assign port_req[i]              = req_q;
      assign port_we[i]               = we_q;
      assign port_a[i*WA +: WA]       = a_q;
      assign port_ds[i*LANES +: LANES] = ds_q;
      assign port_d[i*DW +: DW]       = d_q;

      assign unused_bits = ^{head.addr, oh};
   end

   always_comb begin
      wr_d         = ioctl_wr;
      dl_d         = ioctl_download && (ioctl_index == ROM_INDEX);
      stb_d        = ioctl_wr && !wr_q && dl_d;
      addr_d       = ioctl_addr;
      dout_d       = ioctl_dout;
      overflow_d   = overflow_q || (|drop_v);
      drain_d      = drain_q;
      rom_loaded_d = rom_loaded_q;
      // A strobe still in the pipeline counts as outstanding work.
      if (dl_q && !dl_d) begin
         drain_d = 1'b1;
      end else if (drain_q && !stb_q && !(|active_v)) begin
         drain_d      = 1'b0;
         rom_loaded_d = 1'b1;
      end
      if (reset_req || !rom_loaded_q || ioctl_download || drain_q) cnt_d = RESET_HOLD;
      else if (cnt_q != 16'd0)                                     cnt_d = cnt_q - 16'd1;
      else                                                         cnt_d = cnt_q;
      core_reset_d = (cnt_q != 16'd0);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_q         <= 1'b0;
         dl_q         <= 1'b0;
         stb_q        <= 1'b0;
         addr_q       <= '0;
         dout_q       <= '0;
         drain_q      <= 1'b0;
         rom_loaded_q <= 1'b0;
         overflow_q   <= 1'b0;
         cnt_q        <= RESET_HOLD;
         core_reset_q <= 1'b1;
      end else begin
         wr_q         <= wr_d;
         dl_q         <= dl_d;
         stb_q        <= stb_d;
         addr_q       <= addr_d;
         dout_q       <= dout_d;
         drain_q      <= drain_d;
         rom_loaded_q <= rom_loaded_d;
         overflow_q   <= overflow_d;
         cnt_q        <= cnt_d;
         core_reset_q <= core_reset_d;
      end
   end

   assign ioctl_wait = |near_v;
   assign rom_loaded = rom_loaded_q;
   assign overflow   = overflow_q;
   assign core_reset = core_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_router.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rom_dl_router: directed stimulus with a write scoreboard.  Rev 1.0|
// +----------------------------------------------------------------------+
module tb_rom_dl_router;

   localparam int NP    = 2;
   localparam int AW    = 25;
   localparam int DW    = 16;
   localparam int LANES = 2;
   localparam int WA    = 24;

   logic                clk_sys = 1'b0;
   logic                reset, ioctl_download, ioctl_wr, reset_req;
   logic [7:0]          ioctl_index, ioctl_dout;
   logic [AW-1:0]       ioctl_addr;
   logic [NP*AW-1:0]    region_base, region_end;
   logic [NP-1:0]       port_req, port_ack, port_we;
   logic [NP*WA-1:0]    port_a;
   logic [NP*LANES-1:0] port_ds;
   logic [NP*DW-1:0]    port_d;
   logic                ioctl_wait, rom_loaded, core_reset, overflow;
   logic [NP-1:0]       ack_en = '0;

   int checks = 0;
   int errors = 0;
   int wr_cnt [NP] = '{0, 0};

   typedef struct packed {
      logic [WA-1:0]    a;
      logic [LANES-1:0] ds;
      logic [DW-1:0]    d;
   } exp_t;

   exp_t exp_q0[$];
   exp_t exp_q1[$];

   always #5 clk_sys = ~clk_sys;

   rom_dl_router #(
      .NPORTS     (NP),
      .AW         (AW),
      .DW         (DW),
      .FIFO_DEPTH (4),
      .ROM_INDEX  (8'h00),
      .RESET_HOLD (16'd16)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .region_base    (region_base),
      .region_end     (region_end),
      .port_req       (port_req),
      .port_ack       (port_ack),
      .port_a         (port_a),
      .port_ds        (port_ds),
      .port_d         (port_d),
      .port_we        (port_we),
      .reset_req      (reset_req),
      .rom_loaded     (rom_loaded),
      .core_reset     (core_reset),
      .overflow       (overflow)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input int p, input logic [WA-1:0] a, input logic [LANES-1:0] ds,
                            input logic [7:0] b);
      exp_t e;
      e = '{a: a, ds: ds, d: {b, b}};
      if (p == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic check_write(input int p);
      exp_t act, e;
      act = '{a: port_a[p*WA +: WA], ds: port_ds[p*LANES +: LANES], d: port_d[p*DW +: DW]};
      checks++;
      if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
         errors++;
         $display("FAIL write_port%0d: got a=0x%0h ds=%b d=0x%0h, expected no write",
                  p, act.a, act.ds, act.d);
      end else begin
         if (p == 0) e = exp_q0.pop_front();
         else        e = exp_q1.pop_front();
         if (act !== e || port_we[p] !== 1'b1) begin
            errors++;
            $display("FAIL write_port%0d: got a=0x%0h ds=%b d=0x%0h we=%b, expected a=0x%0h ds=%b d=0x%0h we=1",
                     p, act.a, act.ds, act.d, port_we[p], e.a, e.ds, e.d);
         end
      end
   endtask

   // Acknowledge responder: mirrors req onto ack for enabled ports.
   initial begin
      port_ack = 2'b10;
      forever begin
         @(posedge clk_sys);
         #1;
         for (int p = 0; p < NP; p++)
            if (ack_en[p]) port_ack[p] = port_req[p];
      end
   end

   // Monitor: every req toggle outside reset is a write to score.
   initial begin
      logic [NP-1:0] prev;
      logic          rst_prev;
      prev     = '0;
      rst_prev = 1'b1;
      forever begin
         @(negedge clk_sys);
         if (reset || rst_prev) begin
            prev = port_req;
         end else begin
            for (int p = 0; p < NP; p++) begin
               if (port_req[p] !== prev[p]) begin
                  prev[p] = port_req[p];
                  wr_cnt[p]++;
                  check_write(p);
               end
            end
         end
         rst_prev = reset;
      end
   end

   task automatic write_byte(input logic [AW-1:0] addr, input logic [7:0] data);
      @(posedge clk_sys); #1;
      ioctl_addr = addr;
      ioctl_dout = data;
      ioctl_wr   = 1'b1;
      @(posedge clk_sys); #1;
      ioctl_wr   = 1'b0;
      @(posedge clk_sys); #1;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0 || port_we != '0) && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s: drain timeout, got %0d outstanding, expected 0",
                  name, exp_q0.size() + exp_q1.size());
      end
      @(posedge clk_sys); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t_idle, t_load, t_fall, t_rise, n;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index    = 8'h00;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      reset_req      = 1'b0;
      region_base    = {25'h10000, 25'h00000};
      region_end     = {25'h1C000, 25'h10000};
      repeat (3) @(posedge clk_sys);
      #1 reset = 1'b0;

      @(negedge clk_sys);
      check("rst_port_req", port_req, 2'b10);
      check("rst_port_we", port_we, 0);
      check("rst_port_a", port_a, 0);
      check("rst_port_ds", port_ds, 0);
      check("rst_port_d", port_d, 0);
      check("rst_ioctl_wait", ioctl_wait, 0);
      check("rst_overflow", overflow, 0);
      check("rst_rom_loaded", rom_loaded, 0);
      check("rst_core_reset", core_reset, 1);
      ack_en = 2'b11;

      // Index filter: a non-ROM download must not touch any port.
      ioctl_index    = 8'h01;
      ioctl_download = 1'b1;
      write_byte(25'h00003, 8'h55);
      write_byte(25'h10004, 8'h66);
      ioctl_download = 1'b0;
      repeat (10) @(posedge clk_sys);
      @(negedge clk_sys);
      check("idx_filter_writes", wr_cnt[0] + wr_cnt[1], 0);
      check("idx_filter_loaded", rom_loaded, 0);

      // Basic lane routing.
      ioctl_index    = 8'h00;
      ioctl_download = 1'b1;
      expect_wr(0, 24'h000001, 2'b10, 8'hAB);
      write_byte(25'h00003, 8'hAB);
      wait_drain("t1_drain");
      check("t1_port0_count", wr_cnt[0], 1);
      check("t1_port1_idle", wr_cnt[1], 0);

      // Region offset, then broadcast with overlapping regions.
      expect_wr(1, 24'h000002, 2'b01, 8'hC3);
      write_byte(25'h10004, 8'hC3);
      wait_drain("t2a_drain");
      check("t2a_port0_count", wr_cnt[0], 1);
      check("t2a_port1_count", wr_cnt[1], 1);
      region_end[24:0] = 25'h1C000;
      expect_wr(0, 24'h008002, 2'b01, 8'h5A);
      expect_wr(1, 24'h000002, 2'b01, 8'h5A);
      write_byte(25'h10004, 8'h5A);
      wait_drain("t2b_drain");
      check("t2b_port0_count", wr_cnt[0], 2);
      check("t2b_port1_count", wr_cnt[1], 2);
      region_end[24:0] = 25'h10000;

      // Overflow and backpressure with port0 ack frozen.
      ack_en[0] = 1'b0;
      base      = wr_cnt[0];
      for (int k = 0; k < 6; k++) begin
         if (k < 5) expect_wr(0, WA'(8'h80 + k / 2), (k % 2) ? 2'b10 : 2'b01, 8'(8'h30 + k));
         write_byte(25'h00100 + 25'(k), 8'(8'h30 + k));
         @(negedge clk_sys);
         if (k == 3) check("t3_wait_after_4th", ioctl_wait, 1);
         if (k == 4) check("t3_no_overflow_5th", overflow, 0);
         if (k == 5) check("t3_overflow_6th", overflow, 1);
      end
      check("t3_frozen_writes", wr_cnt[0] - base, 1);
      ack_en[0] = 1'b1;
      wait_drain("t3_drain");
      check("t3_writes_after_resume", wr_cnt[0] - base - 1, 4);
      check("t3_overflow_sticky", overflow, 1);
      check("t3_wait_released", ioctl_wait, 0);

      // Completion with two writes pending, then reset release timing.
      ack_en = 2'b00;
      expect_wr(0, 24'h000010, 2'b01, 8'h11);
      expect_wr(1, 24'h000008, 2'b01, 8'h22);
      write_byte(25'h00020, 8'h11);
      write_byte(25'h10010, 8'h22);
      ioctl_download = 1'b0;
      repeat (10) @(posedge clk_sys);
      @(negedge clk_sys);
      check("t5_pending_we", port_we, 2'b11);
      check("t5_not_loaded", rom_loaded, 0);
      check("t5_core_reset_held", core_reset, 1);
      ack_en = 2'b11;
      t_idle = -1; t_load = -1; t_fall = -1;
      for (int k = 0; k < 100 && t_fall < 0; k++) begin
         @(negedge clk_sys);
         if (t_idle < 0 && port_we == '0) t_idle = k;
         if (t_load < 0 && rom_loaded)    t_load = k;
         if (t_load >= 0 && t_fall < 0 && !core_reset) t_fall = k;
      end
      check("t5_loaded_after_idle", t_load - t_idle, 1);
      check("t5_core_reset_fall", t_fall - t_load, 17);

      @(posedge clk_sys); #1 reset_req = 1'b1;
      @(posedge clk_sys); #1 reset_req = 1'b0;
      t_rise = -1; t_fall = -1;
      for (int k = 0; k < 100 && t_fall < 0; k++) begin
         @(negedge clk_sys);
         if (t_rise < 0 && core_reset)                 t_rise = k;
         if (t_rise >= 0 && t_fall < 0 && !core_reset) t_fall = k;
      end
      check("t5_reset_req_rise", t_rise, 1);
      check("t5_reset_req_fall", t_fall, 17);
      check("t5_loaded_kept", rom_loaded, 1);

      // Reset while port0 is busy.
      ack_en[0]      = 1'b0;
      ioctl_download = 1'b1;
      expect_wr(0, 24'h000020, 2'b01, 8'h77);
      write_byte(25'h00040, 8'h77);
      n = 0;
      while (port_we[0] !== 1'b1 && n < 20) begin
         @(negedge clk_sys);
         n++;
      end
      check("t6_busy_reached", port_we[0], 1);
      base = wr_cnt[0];
      @(posedge clk_sys); #1;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      @(posedge clk_sys); #1 reset = 1'b0;
      @(negedge clk_sys);
      check("t6_we_cleared", port_we, 0);
      check("t6_req_eq_ack", port_req, port_ack);
      check("t6_loaded_cleared", rom_loaded, 0);
      repeat (20) @(posedge clk_sys);
      @(negedge clk_sys);
      check("t6_no_more_writes", wr_cnt[0] - base, 0);
      check("t6_we_still_clear", port_we, 0);
      check("t6_loaded_still_clear", rom_loaded, 0);

      check("scoreboard_empty", exp_q0.size() + exp_q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
